// File: rtl/cpu.sv
// ---------------------------------------------------------------------------
// cpu -- multicycle 32-bit RISC core.
//
// One instruction in flight, walking FETCH -> DECODE -> EXEC -> MEM -> WB
// (stages skipped per opcode). 16 x 32-bit general registers (R0 reads as 0),
// internal data memory of DMEM_DEPTH words indexed by the low ALU result bits.
//
// Ports:
//   clk       in   1   system clock, all state updates on rising edge
//   rst       in   1   synchronous active-high reset
//   inst_Din  in  32   instruction word at address pc_out, sampled in FETCH
//   pc_out    out 32   current program counter
//
// Optional build macro: CPU_HALT_EN -- opcode 6'h3F enters a HALT state
// (3'b101) that freezes the core until reset. Undefined: 6'h3F is a NOP.
// ---------------------------------------------------------------------------
module cpu #(
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] PC_RESET   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_Din,
    output logic [31:0] pc_out
);

    localparam int unsigned DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_AND  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ANDI = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_LW   = 6'd5;
    localparam logic [5:0] OP_SW   = 6'd6;
    localparam logic [5:0] OP_BEQ  = 6'd7;
    localparam logic [5:0] OP_J    = 6'd8;
`ifdef CPU_HALT_EN
    localparam logic [5:0] OP_HALT = 6'h3F;
`endif

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100
`ifdef CPU_HALT_EN
        ,
        HALT   = 3'b101
`endif
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] pc_q;
    logic [31:0] pcold_q;
    logic [31:0] ir_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] d_q;
    logic [31:0] aluout_q;
    logic [31:0] mdr_q;
    logic [31:0] regs_q [16];
    logic [31:0] mem    [DMEM_DEPTH];

    logic [31:0] alu_d;

    // Field decode straight from IR
    logic [5:0]  op_code;
    logic [3:0]  inst_rd;
    logic [3:0]  inst_rs1;
    logic [3:0]  inst_rs2;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] j_off;

    assign op_code  = ir_q[31:26];
    assign inst_rd  = ir_q[25:22];
    assign inst_rs1 = ir_q[21:18];
    assign inst_rs2 = ir_q[17:14];
    assign imm_sext = {{18{ir_q[13]}}, ir_q[13:0]};
    assign imm_zext = {18'd0, ir_q[13:0]};
    assign j_off    = {{6{ir_q[25]}}, ir_q[25:0]};

    assign pc_out = pc_q;

    logic [DMEM_AW-1:0] dmem_addr;
    assign dmem_addr = aluout_q[DMEM_AW-1:0];

    // Register file reads; R0 is forced to zero on the read side
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] rd_val;
    assign rs1_val = (inst_rs1 == 4'd0) ? '0 : regs_q[inst_rs1];
    assign rs2_val = (inst_rs2 == 4'd0) ? '0 : regs_q[inst_rs2];
    assign rd_val  = (inst_rd  == 4'd0) ? '0 : regs_q[inst_rd];

    // ALU
    always_comb begin
        alu_d = '0;
        case (op_code)
            OP_AND:               alu_d = a_q & b_q;
            OP_ADD:               alu_d = a_q + b_q;
            OP_SUB:               alu_d = a_q - b_q;
            OP_ANDI:              alu_d = a_q & imm_zext;
            OP_ADDI, OP_LW, OP_SW: alu_d = a_q + imm_sext;
            default:              alu_d = '0;
        endcase
    end

    // Next-state logic: depends only on state and op_code
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (op_code)
                    OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI,
                    OP_LW, OP_SW, OP_BEQ: next_state = EXEC;
`ifdef CPU_HALT_EN
                    OP_HALT:              next_state = HALT;
`endif
                    default:              next_state = FETCH;
                endcase
            end
            EXEC: begin
                case (op_code)
                    OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI: next_state = WB;
                    OP_LW, OP_SW:                             next_state = MEM;
                    default:                                  next_state = FETCH;
                endcase
            end
            MEM:    next_state = (op_code == OP_LW) ? WB : FETCH;
            WB:     next_state = FETCH;
`ifdef CPU_HALT_EN
            HALT:   next_state = HALT;
`endif
            default: next_state = FETCH;
        endcase
    end

    // Datapath and state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc_q     <= PC_RESET;
            pcold_q  <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state <= next_state;
            case (state)
                FETCH: begin
                    ir_q    <= inst_Din;
                    pcold_q <= pc_q;
                    pc_q    <= pc_q + 32'd1;
                end
                DECODE: begin
                    a_q <= rs1_val;
                    b_q <= rs2_val;
                    d_q <= rd_val;
                    if (op_code == OP_J) begin
                        pc_q <= pcold_q + j_off;
                    end
                end
                EXEC: begin
                    aluout_q <= alu_d;
                    // BEQ compares the rd operand (D) against rs1 (A)
                    if (op_code == OP_BEQ && d_q == a_q) begin
                        pc_q <= pcold_q + imm_sext;
                    end
                end
                MEM: begin
                    if (op_code == OP_LW) begin
                        mdr_q <= mem[dmem_addr];
                    end
                end
                WB: begin
                    if (inst_rd != 4'd0) begin
                        regs_q[inst_rd] <= (op_code == OP_LW) ? mdr_q : aluout_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data memory: never cleared; a reset edge blocks a pending store
    always_ff @(posedge clk) begin
        if (!rst && state == MEM && op_code == OP_SW) begin
            mem[dmem_addr] <= d_q;
        end
    end

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

    logic        clk;
    logic        rst;
    logic [31:0] inst_Din;
    logic [31:0] pc_out;

    int unsigned n_assert;
    int unsigned n_fail;

    logic        use_const;
    logic [31:0] const_word;
    logic [31:0] rom [32];

    cpu #(
        .DMEM_DEPTH (256),
        .PC_RESET   (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inst_Din (inst_Din),
        .pc_out   (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb inst_Din = use_const ? const_word : rom[pc_out[4:0]];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [13:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    localparam logic [31:0] NOP = 32'h8000_0000;

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        use_const  = 1'b1;
        const_word = 32'b000000_1010_0101_1111_11110110010000;
        for (int i = 0; i < 32; i++) rom[i] = NOP;

        // ---- Constant AND word ----
        do_reset();
        chk("rst_state", 32'(dut.state), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_op", 32'(dut.op_code), 32'd0);
        chk("rst_rd", 32'(dut.inst_rd), 32'd0);
        tick(1);
        chk("c_state_dec", 32'(dut.state), 32'd1);
        chk("c_op", 32'(dut.op_code), 32'd0);
        chk("c_rd", 32'(dut.inst_rd), 32'hA);
        chk("c_rs1", 32'(dut.inst_rs1), 32'h5);
        chk("c_rs2", 32'(dut.inst_rs2), 32'hF);
        chk("c_pc1", pc_out, 32'd1);
        tick(1);
        chk("c_state_exec", 32'(dut.state), 32'd2);
        tick(1);
        chk("c_state_wb", 32'(dut.state), 32'd4);
        tick(1);
        chk("c_state_fetch", 32'(dut.state), 32'd0);
        chk("c_r10", dut.regs_q[10], 32'd0);
        chk("c_pc_hold", pc_out, 32'd1);
        tick(4);
        chk("c_pc2", pc_out, 32'd2);

        // ---- Program run A ----
        use_const = 1'b0;
        rom[0] = enc(6'd4, 4'd1, 4'd0, 4'd0, 14'd5);        // ADDI R1,R0,5
        rom[1] = enc(6'd4, 4'd2, 4'd0, 4'd0, 14'h3FFD);     // ADDI R2,R0,-3
        rom[2] = enc(6'd1, 4'd3, 4'd1, 4'd2, 14'd0);        // ADD R3,R1,R2
        rom[3] = enc(6'd6, 4'd1, 4'd0, 4'd0, 14'd7);        // SW R1,[R0+7]
        rom[4] = enc(6'd5, 4'd4, 4'd0, 4'd0, 14'd7);        // LW R4,[R0+7]
        rom[5] = enc(6'd7, 4'd1, 4'd0, 4'd0, 14'd10);       // BEQ R1,R0 (not taken)
        rom[6] = enc(6'd2, 4'd5, 4'd2, 4'd1, 14'd0);        // SUB R5,R2,R1
        rom[7] = enc(6'd3, 4'd6, 4'd2, 4'd0, 14'h3FF0);     // ANDI R6,R2,0x3FF0
        rom[8] = enc(6'd4, 4'd0, 4'd1, 4'd0, 14'd9);        // ADDI R0,R1,9
        rom[9] = {6'd8, 26'h3FF_FFF7};                       // J -9
        do_reset();
        tick(4);
        chk("r1", dut.regs_q[1], 32'd5);
        chk("a_pc1", pc_out, 32'd1);
        tick(4);
        chk("r2", dut.regs_q[2], 32'hFFFF_FFFD);
        tick(4);
        chk("r3", dut.regs_q[3], 32'd2);
        tick(3);
        chk("sw_mem_state", 32'(dut.state), 32'd3);
        tick(1);
        chk("sw_done_state", 32'(dut.state), 32'd0);
        chk("m7", dut.mem[7], 32'd5);
        chk("sw_pc", pc_out, 32'd4);
        tick(3);
        chk("lw_mem_state", 32'(dut.state), 32'd3);
        tick(1);
        chk("lw_wb_state", 32'(dut.state), 32'd4);
        tick(1);
        chk("r4", dut.regs_q[4], 32'd5);
        chk("lw_pc", pc_out, 32'd5);
        tick(3);
        chk("beq_nt_state", 32'(dut.state), 32'd0);
        chk("beq_nt_pc", pc_out, 32'd6);
        tick(4);
        chk("r5", dut.regs_q[5], 32'hFFFF_FFF8);
        tick(4);
        chk("r6", dut.regs_q[6], 32'h0000_3FF0);
        tick(4);
        chk("r0", dut.regs_q[0], 32'd0);
        chk("r0_pc", pc_out, 32'd9);
        tick(2);
        chk("j_pc", pc_out, 32'd0);
        chk("j_state", 32'(dut.state), 32'd0);

        // Abort ADD R3 in EXEC with reset
        tick(8);
        tick(2);
        chk("add_exec_state", 32'(dut.state), 32'd2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_state", 32'(dut.state), 32'd0);
        chk("abort_pc", pc_out, 32'd0);
        chk("abort_r3", dut.regs_q[3], 32'd0);
        chk("abort_r1", dut.regs_q[1], 32'd0);
        chk("mem_kept", dut.mem[7], 32'd5);

        // ---- Run B: taken BEQ at PC 4 ----
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        rom[4] = enc(6'd7, 4'd0, 4'd0, 4'd0, 14'h3FFF);     // BEQ R0,R0,-1
        do_reset();
        tick(2);
        chk("nop_pc", pc_out, 32'd1);
        chk("nop_state", 32'(dut.state), 32'd0);
        tick(6);
        chk("pre_beq_pc", pc_out, 32'd4);
        tick(1);
        chk("beq_fetch_pc", pc_out, 32'd5);
        tick(2);
        chk("beq_t_pc", pc_out, 32'd3);
        chk("beq_t_state", 32'(dut.state), 32'd0);

        // ---- Run C: opcode 3F ----
        for (int i = 0; i < 32; i++) rom[i] = NOP;
        rom[0] = 32'hFC00_0000;
        do_reset();
        tick(2);
`ifdef CPU_HALT_EN
        chk("halt_state", 32'(dut.state), 32'd5);
        chk("halt_pc", pc_out, 32'd1);
        tick(20);
        chk("halt_state_hold", 32'(dut.state), 32'd5);
        chk("halt_pc_hold", pc_out, 32'd1);
`else
        chk("3f_nop_state", 32'(dut.state), 32'd0);
        chk("3f_nop_pc", pc_out, 32'd1);
        tick(2);
        chk("3f_nop_pc2", pc_out, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
